// File: rtl/apb_mst_pkg.sv
// Shared types for the APB command master: FSM state encoding, default widths
// and the response payload.
package apb_mst_pkg;

    localparam int unsigned APB_ADDR_WD = 12;
    localparam int unsigned APB_DATA_WD = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mst_state_e;

    typedef struct packed {
        logic [APB_DATA_WD-1:0] rdata;
        logic                   err;
        logic                   timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_mst_timer.sv
// ACCESS-phase wait-state counter; expired flags the last allowed wait cycle.
module apb_mst_timer #(
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic pclk,
    input  logic preset,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int unsigned CNT_WD = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_WD-1:0] CNT_LAST = CNT_WD'(TIMEOUT_CYC - 1);

    logic [CNT_WD-1:0] cnt_q;
    logic [CNT_WD-1:0] cnt_d;

    // Saturates at CNT_LAST so the count never wraps, even if inc is held.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_LAST)) begin
            cnt_d = cnt_q + CNT_WD'(1);
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            cnt_q   <= '0;
            expired <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            expired <= (cnt_d == CNT_LAST);
        end
    end

endmodule

// File: rtl/apb_cmd_master.sv
// APB initiator: turns a valid/ready command into one SETUP/ACCESS transfer and
// returns read data / slave error / timeout on a valid/ready response channel.
module apb_cmd_master
    import apb_mst_pkg::*;
#(
    parameter int unsigned ADDR_WD     = APB_ADDR_WD,
    parameter int unsigned DATA_WD     = APB_DATA_WD,
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic               pclk,
    input  logic               preset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [ADDR_WD-1:0] cmd_addr,
    input  logic [DATA_WD-1:0] cmd_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_WD-1:0] rsp_rdata,
    output logic               rsp_err,
    output logic               rsp_timeout,
    output logic               psel,
    output logic               penable,
    output logic               pwrite,
    output logic [ADDR_WD-1:0] paddr,
    output logic [DATA_WD-1:0] pwdata,
    input  logic [DATA_WD-1:0] prdata,
    input  logic               pready,
    input  logic               pslverr
);

    apb_mst_state_e     state_q, state_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               psel_q, psel_d;
    logic               penable_q, penable_d;
    logic               pwrite_q, pwrite_d;
    logic [ADDR_WD-1:0] paddr_q, paddr_d;
    logic [DATA_WD-1:0] pwdata_q, pwdata_d;
    logic               rsp_valid_q, rsp_valid_d;
    apb_rsp_t           rsp_q, rsp_d;

    logic timer_clr;
    logic timer_inc;
    logic timer_expired;

    assign timer_clr = (state_q == IDLE) && cmd_valid;
    assign timer_inc = (state_q == ACCESS) && !pready;

    apb_mst_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .pclk    (pclk),
        .preset  (preset),
        .clr     (timer_clr),
        .inc     (timer_inc),
        .expired (timer_expired)
    );

    // Next-state and next-register values; everything holds unless changed.
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_d       = rsp_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    pwrite_d    = cmd_write;
                    paddr_d     = cmd_addr;
                    pwdata_d    = cmd_wdata;
                    psel_d      = 1'b1;
                    cmd_ready_d = 1'b0;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // pready wins over a timeout landing in the same cycle.
                if (pready) begin
                    rsp_d.rdata   = (!pwrite_q && !pslverr) ? APB_DATA_WD'(prdata) : '0;
                    rsp_d.err     = pslverr;
                    rsp_d.timeout = 1'b0;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else if (timer_expired) begin
                    rsp_d.rdata   = '0;
                    rsp_d.err     = 1'b1;
                    rsp_d.timeout = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = DATA_WD'(rsp_q.rdata);
    assign rsp_err     = rsp_q.err;
    assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master with a short timeout (TIMEOUT_CYC = 4).
module tb_apb_cmd_master;

    localparam int unsigned ADDR_WD     = 12;
    localparam int unsigned DATA_WD     = 32;
    localparam int unsigned TIMEOUT_CYC = 4;

    logic               pclk;
    logic               preset;
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_write;
    logic [ADDR_WD-1:0] cmd_addr;
    logic [DATA_WD-1:0] cmd_wdata;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [DATA_WD-1:0] rsp_rdata;
    logic               rsp_err;
    logic               rsp_timeout;
    logic               psel;
    logic               penable;
    logic               pwrite;
    logic [ADDR_WD-1:0] paddr;
    logic [DATA_WD-1:0] pwdata;
    logic [DATA_WD-1:0] prdata;
    logic               pready;
    logic               pslverr;

    int checks = 0;
    int errors = 0;

    apb_cmd_master #(
        .ADDR_WD     (ADDR_WD),
        .DATA_WD     (DATA_WD),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .pclk        (pclk),
        .preset      (preset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge pclk);
    endtask

    task automatic send_cmd(input logic wr, input logic [ADDR_WD-1:0] a, input logic [DATA_WD-1:0] d);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    initial begin
        preset    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        step();
        step();
        preset = 1'b0;

        // Reset state
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);

        // Zero-wait write
        pready = 1'b1;
        send_cmd(1'b1, 12'h004, 32'h0003_00FF);
        step();
        cmd_valid = 1'b0;
        chk("wr_setup_psel", psel, 1);
        chk("wr_setup_penable", penable, 0);
        chk("wr_setup_cmd_ready", cmd_ready, 0);
        chk("wr_paddr", paddr, 12'h004);
        chk("wr_pwrite", pwrite, 1);
        chk("wr_pwdata", pwdata, 32'h0003_00FF);
        step();
        chk("wr_access_psel", psel, 1);
        chk("wr_access_penable", penable, 1);
        chk("wr_access_rsp_valid", rsp_valid, 0);
        step();
        chk("wr_resp_psel", psel, 0);
        chk("wr_resp_penable", penable, 0);
        chk("wr_rsp_valid", rsp_valid, 1);
        chk("wr_rsp_err", rsp_err, 0);
        chk("wr_rsp_rdata", rsp_rdata, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("wr_done_rsp_valid", rsp_valid, 0);
        chk("wr_done_cmd_ready", cmd_ready, 1);

        // Read with 3 wait states; pready arrives in the 4th ACCESS cycle
        pready = 1'b0;
        send_cmd(1'b0, 12'h008, 32'hFFFF_FFFF);
        step();
        cmd_valid = 1'b0;
        chk("rd3_setup_psel", psel, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rd3_wait_penable", penable, 1);
            chk("rd3_wait_paddr", paddr, 12'h008);
            chk("rd3_wait_rsp_valid", rsp_valid, 0);
        end
        pready = 1'b1;
        prdata = 32'h0000_1234;
        step();
        pready = 1'b0;
        prdata = '0;
        chk("rd3_rsp_valid", rsp_valid, 1);
        chk("rd3_rsp_rdata", rsp_rdata, 32'h0000_1234);
        chk("rd3_rsp_err", rsp_err, 0);
        chk("rd3_rsp_timeout", rsp_timeout, 0);
        chk("rd3_psel", psel, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Slave error on read
        pready  = 1'b1;
        pslverr = 1'b1;
        prdata  = 32'hDEAD_BEEF;
        send_cmd(1'b0, 12'h00C, 32'h0);
        step();
        cmd_valid = 1'b0;
        step();
        step();
        chk("slverr_rsp_valid", rsp_valid, 1);
        chk("slverr_rsp_err", rsp_err, 1);
        chk("slverr_rsp_timeout", rsp_timeout, 0);
        chk("slverr_rsp_rdata", rsp_rdata, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        pslverr   = 1'b0;

        // Timeout: pready held low for 4 ACCESS cycles
        pready = 1'b0;
        prdata = 32'h5555_AAAA;
        send_cmd(1'b0, 12'h010, 32'h0);
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("to_access_psel", psel, 1);
            chk("to_access_rsp_valid", rsp_valid, 0);
        end
        step();
        chk("to_psel", psel, 0);
        chk("to_penable", penable, 0);
        chk("to_rsp_valid", rsp_valid, 1);
        chk("to_rsp_err", rsp_err, 1);
        chk("to_rsp_timeout", rsp_timeout, 1);
        chk("to_rsp_rdata", rsp_rdata, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // pready in the 4th ACCESS cycle of a write: normal completion, prdata ignored
        send_cmd(1'b1, 12'h014, 32'hCAFE_0001);
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        pready = 1'b1;
        prdata = 32'hA5A5_A5A5;
        step();
        pready = 1'b0;
        chk("to4_rsp_valid", rsp_valid, 1);
        chk("to4_rsp_timeout", rsp_timeout, 0);
        chk("to4_rsp_err", rsp_err, 0);
        chk("to4_rsp_rdata", rsp_rdata, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Response backpressure with a second command held pending
        pready = 1'b1;
        send_cmd(1'b1, 12'h020, 32'h0000_0011);
        step();
        send_cmd(1'b1, 12'h024, 32'h0000_0022);
        chk("bp_cmd_ready_setup", cmd_ready, 0);
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_psel", psel, 0);
            chk("bp_paddr", paddr, 12'h020);
            chk("bp_rsp_err", rsp_err, 0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("bp_idle_rsp_valid", rsp_valid, 0);
        chk("bp_idle_cmd_ready", cmd_ready, 1);
        chk("bp_idle_psel", psel, 0);
        step();
        cmd_valid = 1'b0;
        chk("bp2_psel", psel, 1);
        chk("bp2_paddr", paddr, 12'h024);
        chk("bp2_pwdata", pwdata, 32'h0000_0022);
        step();
        step();
        chk("bp2_rsp_valid", rsp_valid, 1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Reset during ACCESS
        pready = 1'b0;
        send_cmd(1'b0, 12'h030, 32'h0);
        step();
        cmd_valid = 1'b0;
        step();
        chk("mr_access_penable", penable, 1);
        preset = 1'b1;
        step();
        chk("mr_psel", psel, 0);
        chk("mr_penable", penable, 0);
        chk("mr_rsp_valid", rsp_valid, 0);
        chk("mr_cmd_ready", cmd_ready, 1);
        preset = 1'b0;
        step();
        chk("mr_after_psel", psel, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
- APB initiator: converts a simple valid/ready command stream into APB SETUP/ACCESS transfers, then returns a response (read data, slave error, timeout) on a valid/ready response channel.
- Sits between the system controller / debug bridge and APB peripherals, for example the wdog register block.
- Drives psel/penable/pwrite/paddr/pwdata and samples pready/prdata/pslverr.
- Single outstanding transfer.

Parameters:
- ADDR_WD, 12, APB address width (peripheral slot size).
- DATA_WD, 32, APB data width.
- TIMEOUT_CYC, 256, maximum ACCESS-phase cycles with pready low before the transfer is aborted; must be ≥ 2.

Ports:
- pclk  input  1  APB clock.
- preset  input  1  Synchronous reset, active-high.
- cmd_valid  input  1  Command present.
- cmd_ready  output  1  Command accepted when valid & ready.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDR_WD  Byte address.
- cmd_wdata  input  DATA_WD  Write data.
- rsp_valid  output  1  Response present.
- rsp_ready  input  1  Response consumed when valid & ready.
- rsp_rdata  output  DATA_WD  Read data; 0 for writes, errors and timeouts.
- rsp_err  output  1  pslverr seen or timeout.
- rsp_timeout  output  1  Transfer aborted by timeout.
- psel  output  1  APB select.
- penable  output  1  APB enable.
- pwrite  output  1  APB direction.
- paddr  output  ADDR_WD  APB address.
- pwdata  output  DATA_WD  APB write data.
- prdata  input  DATA_WD  APB read data.
- pready  input  1  APB ready / wait-state.
- pslverr  input  1  APB slave error.

Behaviour:
- Clock and reset: one clock, pclk. Reset is synchronous and active-high on preset. All state updates occur on the rising edge of pclk.
- Reset values:
  - state = IDLE.
  - cmd_ready = 1 once in IDLE.
  - psel, penable, pwrite = 0.
  - paddr, pwdata = 0.
  - rsp_valid, rsp_err, rsp_timeout = 0.
  - rsp_rdata = 0.
  - Wait counter = 0.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid: register write/addr/wdata into pwrite/paddr/pwdata, then go to SETUP.
- SETUP (exactly one cycle):
  - psel = 1, penable = 0.
  - Go to ACCESS.
- ACCESS:
  - psel = 1, penable = 1.
  - Wait counter increments every cycle with pready = 0.
  - If pready = 1: capture rsp_rdata = (read & !pslverr) ? prdata : 0, rsp_err = pslverr, rsp_timeout = 0. Drop psel/penable at the same edge and go to RESP.
  - Else, if counter == TIMEOUT_CYC-1: abort with rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0. Drop psel/penable and go to RESP.
  - pready takes priority over timeout in the same cycle.
- RESP:
  - rsp_valid = 1; response fields held stable.
  - On rsp_ready: clear rsp_valid, go to IDLE.
  - cmd_ready = 0 in RESP; back-to-back commands therefore have one IDLE cycle between them.
- APB output stability:
  - paddr/pwrite/pwdata are constant from SETUP through the last ACCESS cycle.
  - They retain their last values in IDLE/RESP; no toggling when psel = 0.
- Latency:
  - Command accept at edge N → SETUP cycle N+1 → first ACCESS cycle N+2.
  - With zero wait states, rsp_valid is asserted in cycle N+3.
  - Each wait state adds one cycle.
- Counter:
  - Width $clog2(TIMEOUT_CYC).
  - Clears on SETUP entry; no wrap is possible because the abort fires first.
- Reset mid-transfer: psel/penable drop at the reset edge; any pending response is discarded; rsp_valid = 0.
- cmd_* inputs are ignored outside IDLE.
- pslverr is sampled only when psel & penable & pready.
- prdata is ignored for writes.

Decomposition:
- Package apb_mst_pkg:
  - typedef enum logic[1:0] apb_mst_state_e {IDLE, SETUP, ACCESS, RESP}.
  - Localparam defaults for ADDR_WD/DATA_WD.
  - Response struct {rdata, err, timeout}.
- Sub-module apb_mst_timer:
  - Inputs: clr, inc.
  - Output: expired.
  - Parameter: TIMEOUT_CYC.
- Top level holds the FSM and the APB/response registers.

Test Plan:
- Zero-wait write:
  - Stimulus: cmd write addr=0x004, wdata=0x0003_00FF; pready tied 1.
  - Response: psel high for 2 cycles, penable in the 2nd; rsp_valid at N+3 with err=0, rdata=0.
- Read with 3 wait states:
  - Stimulus: addr=0x008; pready low for 3 ACCESS cycles, then high with prdata=0x0000_1234.
  - Response: rsp_rdata=0x1234, err=0; rsp_valid at N+6; paddr stable throughout.
- Slave error:
  - Stimulus: read addr=0x00C; pready=1 with pslverr=1 and prdata=0xDEAD_BEEF.
  - Response: rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- Timeout:
  - Stimulus: TIMEOUT_CYC=4; pready held 0.
  - Response: abort after 4 ACCESS cycles; psel drops; rsp err=1, timeout=1.
  - Repeat with pready=1 in the 4th ACCESS cycle: normal completion, timeout=0.
- Response backpressure plus back-to-back commands:
  - Stimulus: rsp_ready low for 5 cycles while cmd_valid is held.
  - Response: cmd_ready=0 and response fields stable in RESP; the second command is accepted only after the rsp handshake and the return to IDLE.
- Mid-transfer reset:
  - Stimulus: assert preset during ACCESS.
  - Response: next edge gives psel=penable=rsp_valid=0, state IDLE, cmd_ready=1.
